mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. Consumes the registered EX/MEM bundle, performs byte/half/word loads and stores to data memory over a req/ack handshake, and stalls the front of the pipe while an access is outstanding. Contains the MEM/WB pipeline register, presenting a registered bundle to writeback. Detects misaligned and timed-out accesses.

## Interface
- MAX_WAIT, 15: cycles in REQ without ack before bus error (1..255)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- validm  in  1  MEM stage holds a real instruction (0 = bubble)
- regwritem, memtoregm, memwritem, jumplinkm  in  1 each  EX/MEM control
- memsizem  in  2  00 word, 01 half, 10 byte, 11 treated as word
- memsignedm  in  1  sign-extend load result (half/byte)
- aluoutm  in  32  effective address / ALU result
- writedatam  in  32  store data (rt)
- writeregm  in  5  destination register
- pcplus4m  in  32  link value
- dmem_req  out  1  access request; addr/we/be/wdata stable while high
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {aluoutm[31:2], 2'b00}
- dmem_be  out  4  byte enables, lane n = bits [8n+7:8n] (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion; rdata valid same cycle
- dmem_rdata  in  32  read word
- stallm  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- excm  out  1  one-cycle pulse: misaligned or bus error
- regwritew, memtoregw, jumplinkw  out  1 each  MEM/WB control
- readdataw, aluoutw, pcplus4w  out  32 each  MEM/WB data
- writeregw  out  5  MEM/WB destination

## Operation
- Access needed: validm & (memtoregm | memwritem).
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0. No dmem_req, no stall; excm=1 that cycle; MEM/WB captures with regwrite=0.
- FSM states IDLE, REQ, DONE.
  - IDLE: access needed & aligned -> stallm=1, go REQ. Otherwise stallm=0, MEM/WB captures EX/MEM inputs at edge.
  - REQ: dmem_req=1, stallm=1, wait counter increments. ack -> latch extended load data, go DONE. Counter reaches MAX_WAIT without ack -> excm=1, go DONE with error flag set.
  - DONE: stallm=0; MEM/WB captures (regwrite forced 0 if error flag); go IDLE; clear counter and flag.
- Store lanes: word be=1111, wdata=rt; half be=addr[1]?1100:0011, wdata={2{rt[15:0]}}; byte be=1<<addr[1:0], wdata={4{rt[7:0]}}. Loads drive be=1111, we=0.
- Load extract: rdata >> 8*addr[1:0], then 16/8-bit sign- or zero-extend per memsignedm; word passes unchanged.
- validm=0: MEM/WB captures a bubble (all control 0).
- Ack outside REQ ignored.

## Timing
- Non-memory instruction: 1 cycle, no stall.
- Memory op, ack in first REQ cycle: IDLE(stall) -> REQ(stall) -> DONE; MEM/WB loads at end of DONE; 3 cycles total, 2 stall cycles. Each extra ack-wait cycle adds one.
- Bus error: MAX_WAIT REQ cycles, then DONE.
- dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata combinational from state and EX/MEM inputs (inputs frozen by stall).
- Reset (async): state IDLE, counter 0, error flag 0; all MEM/WB outputs 0; dmem_req, stallm, excm 0 immediately, including mid-REQ (access abandoned, no DONE).

## Structure
- Shared package mips_pkg: memsize encodings (MS_WORD, MS_HALF, MS_BYTE), FSM state enum, 32-bit word width constant.
- Sub-module mem_align: combinational store lane/be generation and load extract/extend; FSM, counter, and MEM/WB register in mem_stage.

## Test plan
- sw aluoutm=0x100, writedatam=0xDEADBEEF, ack in first REQ -> addr=0x100, be=1111, wdata=0xDEADBEEF, stallm high 2 cycles, regwritew=0.
- lb aluoutm=0x203, signed, rdata=0x80112233 -> be=1111, readdataw=0xFFFFFF80; unsigned -> 0x00000080.
- sh aluoutm=0x302, writedatam=0x0000ABCD -> be=1100, wdata=0xABCDABCD; lhu at 0x302, rdata=0xBEEF0000 -> readdataw=0x0000BEEF.
- lw aluoutm=0x101 -> no dmem_req, stallm=0, excm pulse, regwritew=0 next cycle.
- lw with ack held low, MAX_WAIT=4 -> 4 REQ cycles, excm pulse, DONE, regwritew=0, stall released.
- Reset asserted during REQ -> dmem_req, stallm drop same cycle; after release, add with aluoutm=7 passes in 1 cycle: aluoutw=7.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, memsize codes, MEM FSM states.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] MS_WORD = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } mstate_e;

  // Half must be 2-aligned, word (and the unused 11 code) 4-aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MS_HALF: misaligned = a[0];
      MS_BYTE: misaligned = 1'b0;
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extract / extend for loads.
module mem_align
  import mips_pkg::*;
#(
  parameter int NUM_LANES = WORD_W / 8
) (
  input  logic [1:0]        memsize,
  input  logic [1:0]        addr_lo,
  input  logic              memwrite,
  input  logic              memsigned,
  input  logic [WORD_W-1:0] rt,
  input  logic [WORD_W-1:0] rdata,
  output logic [NUM_LANES-1:0] be,
  output logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ldata
);

  logic [WORD_W-1:0] shifted;

  // Per-lane enable and data select; loads always enable every lane.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LI = 2'(l);
    logic en;
    always_comb begin
      case (memsize)
        MS_HALF: en = (LI[1] == addr_lo[1]);
        MS_BYTE: en = (LI == addr_lo);
        default: en = 1'b1;
      endcase
    end
    assign be[l] = memwrite ? en : 1'b1;
    always_comb begin
      case (memsize)
        MS_HALF: wdata[8*l +: 8] = rt[8*(l%2) +: 8];
        MS_BYTE: wdata[8*l +: 8] = rt[7:0];
        default: wdata[8*l +: 8] = rt[8*l +: 8];
      endcase
    end
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    case (memsize)
      MS_HALF: ldata = {{16{memsigned & shifted[15]}}, shifted[15:0]};
      MS_BYTE: ldata = {{24{memsigned & shifted[7]}},  shifted[7:0]};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data-memory req/ack sequencing, stall, fault detect, MEM/WB reg.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validm,
  input  logic              regwritem,
  input  logic              memtoregm,
  input  logic              memwritem,
  input  logic              jumplinkm,
  input  logic [1:0]        memsizem,
  input  logic              memsignedm,
  input  logic [WORD_W-1:0] aluoutm,
  input  logic [WORD_W-1:0] writedatam,
  input  logic [4:0]        writeregm,
  input  logic [WORD_W-1:0] pcplus4m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              stallm,
  output logic              excm,
  output logic              regwritew,
  output logic              memtoregw,
  output logic              jumplinkw,
  output logic [WORD_W-1:0] readdataw,
  output logic [WORD_W-1:0] aluoutw,
  output logic [WORD_W-1:0] pcplus4w,
  output logic [4:0]        writeregw
);

  mstate_e           state, nstate;
  logic [7:0]        wcnt;
  logic              err_q;
  logic [WORD_W-1:0] ld_q, ldata;
  logic              access, mis, start, timeout, capture;

  mem_align u_align (
    .memsize   (memsizem),
    .addr_lo   (aluoutm[1:0]),
    .memwrite  (memwritem),
    .memsigned (memsignedm),
    .rt        (writedatam),
    .rdata     (dmem_rdata),
    .be        (dmem_be),
    .wdata     (dmem_wdata),
    .ldata     (ldata)
  );

  assign access    = validm & (memtoregm | memwritem);
  assign mis       = access & misaligned(memsizem, aluoutm[1:0]);
  assign start     = (state == S_IDLE) & access & ~mis;
  assign timeout   = (wcnt == 8'(MAX_WAIT - 1));
  assign capture   = ((state == S_IDLE) & ~start) | (state == S_DONE);

  assign dmem_req  = (state == S_REQ);
  assign dmem_we   = memwritem;
  assign dmem_addr = {aluoutm[WORD_W-1:2], 2'b00};

  // Gated by reset so an abandoned access stops stalling the front immediately.
  assign stallm = ~reset & (start | (state == S_REQ));
  assign excm   = ~reset & (((state == S_IDLE) & mis) |
                            ((state == S_REQ) & ~dmem_ack & timeout));

  // Next-state: ack wins over a timeout landing in the same cycle.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (start) nstate = S_REQ;
      S_REQ:  if (dmem_ack || timeout) nstate = S_DONE;
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // FSM state, ack-wait counter, error flag, and latched load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= '0;
      err_q <= 1'b0;
      ld_q  <= '0;
    end else begin
      state <= nstate;
      if (state == S_REQ) begin
        wcnt <= wcnt + 8'd1;
        if (dmem_ack)     ld_q  <= ldata;
        else if (timeout) err_q <= 1'b1;
      end else if (state == S_DONE) begin
        wcnt  <= '0;
        err_q <= 1'b0;
      end
    end
  end

  // MEM/WB register; while stalled it takes a bubble so WB never repeats an op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwritew <= 1'b0;
      memtoregw <= 1'b0;
      jumplinkw <= 1'b0;
      readdataw <= '0;
      aluoutw   <= '0;
      pcplus4w  <= '0;
      writeregw <= '0;
    end else if (capture) begin
      regwritew <= validm & regwritem & ~mis & ~((state == S_DONE) & err_q);
      memtoregw <= validm & memtoregm;
      jumplinkw <= validm & jumplinkm;
      readdataw <= (state == S_DONE) ? ld_q : '0;
      aluoutw   <= aluoutm;
      pcplus4w  <= pcplus4m;
      writeregw <= writeregm;
    end else begin
      regwritew <= 1'b0;
      memtoregw <= 1'b0;
      jumplinkw <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expectations, monitor pops on bus/WB events.
module tb_mem_stage;
  import mips_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        validm = 0, regwritem = 0, memtoregm = 0, memwritem = 0, jumplinkm = 0;
  logic [1:0]  memsizem = 0;
  logic        memsignedm = 0;
  logic [31:0] aluoutm = 0, writedatam = 0, pcplus4m = 0;
  logic [4:0]  writeregm = 0;
  logic        dmem_req, dmem_we, dmem_ack = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0]  dmem_be;
  logic        stallm, excm, regwritew, memtoregw, jumplinkw;
  logic [31:0] readdataw, aluoutw, pcplus4w;
  logic [4:0]  writeregw;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .validm(validm), .regwritem(regwritem),
    .memtoregm(memtoregm), .memwritem(memwritem), .jumplinkm(jumplinkm),
    .memsizem(memsizem), .memsignedm(memsignedm), .aluoutm(aluoutm),
    .writedatam(writedatam), .writeregm(writeregm), .pcplus4m(pcplus4m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stallm(stallm), .excm(excm),
    .regwritew(regwritew), .memtoregw(memtoregw), .jumplinkw(jumplinkw),
    .readdataw(readdataw), .aluoutw(aluoutw), .pcplus4w(pcplus4w),
    .writeregw(writeregw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        regwrite, memtoreg, jumplink, chk_rd;
    logic [31:0] readdata, aluout, pcplus4;
    logic [4:0]  writereg;
    int          stalls;
    logic        exc;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   chk_cnt = 0, pass_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic wb_t wbx(input logic rw, m2r, jl, chk, input logic [31:0] rd, a,
                              input logic [4:0] wr, input int st, input logic ex);
    wb_t e;
    e.regwrite = rw; e.memtoreg = m2r; e.jumplink = jl; e.chk_rd = chk;
    e.readdata = rd; e.aluout = a; e.pcplus4 = 32'h1000 + a;
    e.writereg = wr; e.stalls = st; e.exc = ex;
    return e;
  endfunction

  function automatic bus_t bx(input logic [31:0] a, input logic we, input logic [3:0] be,
                              input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wd;
    return b;
  endfunction

  // Monitor: a bus access is checked on the first REQ cycle, a WB capture the
  // cycle after any unstalled valid cycle, together with stall/exc seen since.
  initial begin
    bit   pend = 0, reqp = 0, cexc = 0, exs = 0;
    int   scnt = 0, cst = 0;
    wb_t  e;
    bus_t b;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0; reqp = 0; scnt = 0; exs = 0;
      end else begin
        if (pend) begin
          if (wb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL wb_unexpected: capture aluoutw=0x%08h, none expected", aluoutw);
          end else begin
            e = wb_q.pop_front();
            check("regwritew", 32'(regwritew), 32'(e.regwrite));
            check("memtoregw", 32'(memtoregw), 32'(e.memtoreg));
            check("jumplinkw", 32'(jumplinkw), 32'(e.jumplink));
            check("aluoutw",   aluoutw,        e.aluout);
            check("pcplus4w",  pcplus4w,       e.pcplus4);
            check("writeregw", 32'(writeregw), 32'(e.writereg));
            if (e.chk_rd) check("readdataw", readdataw, e.readdata);
            check("stall_cycles", 32'(cst), 32'(e.stalls));
            check("excm_seen", 32'(cexc), 32'(e.exc));
          end
        end
        pend = 0;
        if (dmem_req && !reqp) begin
          if (bus_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL bus_unexpected: dmem_addr=0x%08h, none expected", dmem_addr);
          end else begin
            b = bus_q.pop_front();
            check("dmem_addr", dmem_addr, b.addr);
            check("dmem_we",   32'(dmem_we), 32'(b.we));
            check("dmem_be",   32'(dmem_be), 32'(b.be));
            if (b.we) check("dmem_wdata", dmem_wdata, b.wdata);
          end
        end
        reqp = dmem_req;
        if (stallm) scnt++;
        if (excm) exs = 1;
        if (!stallm) begin
          if (validm) begin pend = 1; cst = scnt; cexc = exs; end
          scnt = 0; exs = 0;
        end
      end
    end
  end

  // Driver: entered at posedge+1; holds inputs while stalled, acks on REQ cycle
  // ack_at (0 = never), returns at posedge+1 after the capturing edge.
  task automatic run_op(input logic v, rw, m2r, mw, jl, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, wd, input logic [4:0] wr,
                        input int ack_at, input logic [31:0] rd);
    int reqc = 0;
    bit fin = 0;
    validm = v; regwritem = rw; memtoregm = m2r; memwritem = mw; jumplinkm = jl;
    memsizem = sz; memsignedm = sg; aluoutm = a; writedatam = wd; writeregm = wr;
    pcplus4m = 32'h1000 + a;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (dmem_req) begin
        reqc++;
        if (reqc == ack_at) begin dmem_ack = 1; dmem_rdata = rd; end
      end
      #1 fin = !stallm;
      @(posedge clk); #1;
      dmem_ack = 0; dmem_rdata = 0;
    end
    if (!fin) begin
      chk_cnt++;
      $display("FAIL op_timeout: stallm still 1 at aluoutm=0x%08h, expected release", a);
    end
  endtask

  initial begin
    // reset state
    #2;
    check("rst_regwritew", 32'(regwritew), 0);
    check("rst_readdataw", readdataw, 0);
    check("rst_aluoutw",   aluoutw, 0);
    check("rst_dmem_req",  32'(dmem_req), 0);
    check("rst_stallm",    32'(stallm), 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // sw word
    bus_q.push_back(bx(32'h100, 1, 4'b1111, 32'hDEADBEEF));
    wb_q.push_back(wbx(0, 0, 0, 0, 0, 32'h100, 0, 2, 0));
    run_op(1, 0, 0, 1, 0, MS_WORD, 0, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    // lb signed / unsigned
    bus_q.push_back(bx(32'h200, 0, 4'b1111, 0));
    wb_q.push_back(wbx(1, 1, 0, 1, 32'hFFFFFF80, 32'h203, 5, 2, 0));
    run_op(1, 1, 1, 0, 0, MS_BYTE, 1, 32'h203, 0, 5, 1, 32'h80112233);
    bus_q.push_back(bx(32'h200, 0, 4'b1111, 0));
    wb_q.push_back(wbx(1, 1, 0, 1, 32'h00000080, 32'h203, 6, 2, 0));
    run_op(1, 1, 1, 0, 0, MS_BYTE, 0, 32'h203, 0, 6, 1, 32'h80112233);
    // sh upper half
    bus_q.push_back(bx(32'h300, 1, 4'b1100, 32'hABCDABCD));
    wb_q.push_back(wbx(0, 0, 0, 0, 0, 32'h302, 0, 2, 0));
    run_op(1, 0, 0, 1, 0, MS_HALF, 0, 32'h302, 32'h0000ABCD, 0, 1, 0);
    // lhu, ack on second REQ cycle
    bus_q.push_back(bx(32'h300, 0, 4'b1111, 0));
    wb_q.push_back(wbx(1, 1, 0, 1, 32'h0000BEEF, 32'h302, 7, 3, 0));
    run_op(1, 1, 1, 0, 0, MS_HALF, 0, 32'h302, 0, 7, 2, 32'hBEEF0000);
    // sb lane 1
    bus_q.push_back(bx(32'h100, 1, 4'b0010, 32'h77777777));
    wb_q.push_back(wbx(0, 0, 0, 0, 0, 32'h101, 0, 2, 0));
    run_op(1, 0, 0, 1, 0, MS_BYTE, 0, 32'h101, 32'h12345677, 0, 1, 0);
    // lh signed, upper half
    bus_q.push_back(bx(32'h204, 0, 4'b1111, 0));
    wb_q.push_back(wbx(1, 1, 0, 1, 32'hFFFF8001, 32'h206, 8, 2, 0));
    run_op(1, 1, 1, 0, 0, MS_HALF, 1, 32'h206, 0, 8, 1, 32'h80010000);
    // lw, ack on third REQ cycle
    bus_q.push_back(bx(32'h104, 0, 4'b1111, 0));
    wb_q.push_back(wbx(1, 1, 0, 1, 32'hCAFEF00D, 32'h104, 9, 4, 0));
    run_op(1, 1, 1, 0, 0, MS_WORD, 0, 32'h104, 0, 9, 3, 32'hCAFEF00D);
    // misaligned lw / lh: no bus access, exception, no writeback
    wb_q.push_back(wbx(0, 1, 0, 0, 0, 32'h101, 4, 0, 1));
    run_op(1, 1, 1, 0, 0, MS_WORD, 0, 32'h101, 0, 4, 0, 0);
    wb_q.push_back(wbx(0, 1, 0, 0, 0, 32'h301, 4, 0, 1));
    run_op(1, 1, 1, 0, 0, MS_HALF, 1, 32'h301, 0, 4, 0, 0);
    // bus timeout: IDLE stall + MW REQ cycles
    bus_q.push_back(bx(32'h400, 0, 4'b1111, 0));
    wb_q.push_back(wbx(0, 1, 0, 0, 0, 32'h400, 3, 1 + MW, 1));
    run_op(1, 1, 1, 0, 0, MS_WORD, 0, 32'h400, 0, 3, 0, 0);
    // non-memory link op: single cycle
    wb_q.push_back(wbx(1, 0, 1, 0, 0, 32'h55, 31, 0, 0));
    run_op(1, 1, 0, 0, 1, MS_WORD, 0, 32'h55, 0, 31, 0, 0);
    // bubble clears control
    run_op(0, 1, 0, 0, 1, MS_WORD, 0, 32'h66, 0, 2, 0, 0);
    check("bubble_regwritew", 32'(regwritew), 0);
    check("bubble_jumplinkw", 32'(jumplinkw), 0);

    // reset during REQ
    bus_q.push_back(bx(32'h500, 0, 4'b1111, 0));
    validm = 1; regwritem = 1; memtoregm = 1; memwritem = 0; jumplinkm = 0;
    memsizem = MS_WORD; aluoutm = 32'h500; writeregm = 5'd10; pcplus4m = 32'h1500;
    @(posedge clk); #1;
    check("req_before_rst", 32'(dmem_req), 1);
    @(negedge clk); #1;
    reset = 1;
    #1;
    check("rst_mid_dmem_req", 32'(dmem_req), 0);
    check("rst_mid_stallm",   32'(stallm), 0);
    check("rst_mid_excm",     32'(excm), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    wb_q.push_back(wbx(1, 0, 0, 0, 0, 32'h7, 2, 0, 0));
    run_op(1, 1, 0, 0, 0, MS_WORD, 0, 32'h7, 0, 2, 0, 0);

    validm = 0;
    repeat (3) @(posedge clk);
    #1;
    check("bus_q_drained", 32'(bus_q.size()), 0);
    check("wb_q_drained",  32'(wb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
